// File: rtl/led_shift_out.sv
// Serial shifter for a 74HC595-style LED driver chain, MSB first.
// Define LED_SHIFT_PENDING_EN to buffer one frame committed while busy.
module led_shift_out #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fc,
    input  logic [WIDTH-1:0] frame,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             sdata,
    output logic             latch
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;

    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DLAST = DW'(CLK_DIV - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shnext;
    logic [BW-1:0]    bitcnt;
    logic [DW-1:0]    div;
    logic             phase;
    logic             start;
    logic [WIDTH-1:0] load;

    assign shnext = shreg << 1;

`ifdef LED_SHIFT_PENDING_EN
    logic             pend_v;
    logic [WIDTH-1:0] pend;

    // A fresh commit in the idle cycle is newer than the buffered one.
    always_comb begin
        start = (state == IDLE) && (fc || pend_v);
        load  = fc ? frame : pend;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_v <= 1'b0;
            pend   <= '0;
        end else if (fc && state != IDLE) begin
            pend_v <= 1'b1;
            pend   <= frame;
        end else if (start) begin
            pend_v <= 1'b0;
        end
    end
`else
    always_comb begin
        start = (state == IDLE) && fc;
        load  = frame;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            div    <= '0;
            phase  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sclk   <= 1'b0;
            sdata  <= 1'b0;
            latch  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shreg  <= load;
                        sdata  <= load[WIDTH-1];
                        bitcnt <= '0;
                        div    <= '0;
                        phase  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div != DLAST) begin
                        div <= div + 1'b1;
                    end else begin
                        div <= '0;
                        if (!phase) begin
                            phase <= 1'b1;
                            sclk  <= 1'b1;
                        end else begin
                            // Data moves only together with the falling sclk.
                            phase <= 1'b0;
                            sclk  <= 1'b0;
                            shreg <= shnext;
                            if (bitcnt == BLAST) begin
                                sdata <= 1'b0;
                                latch <= 1'b1;
                                state <= LATCH;
                            end else begin
                                sdata  <= shnext[WIDTH-1];
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end
                    end
                end
                LATCH: begin
                    if (div != DLAST) begin
                        div <= div + 1'b1;
                    end else begin
                        div   <= '0;
                        latch <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
